wb_systolic_bridge: RTL and testbench
=====================================

# wb_systolic_bridge

Parametrised Wishbone slave that replaces the fixed single-function example slave behind the user project wrapper. It exposes a small register map on the management SoC bus. It feeds N_CH independent operand channels into the systolic array through per-channel FIFOs with valid/ready handshakes, and collects 32-bit array results into a readback FIFO with an interrupt.

## Interface
- BASE_ADDR, 32'h3000_0000: window base; decode on wbs_adr_i[31:8] == BASE_ADDR[31:8].
- N_CH, 4: operand channels, 1..8.
- DATA_W, 8: operand width per channel, 1..32.
- DEPTH, 4: entries per FIFO, power of two, ≥2.
- wb_clk_i  in  1  sole clock.
- wb_rst_ni  in  1  reset, synchronous, active-low.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  Wishbone classic strobe/cycle/write.
- wbs_sel_i  in  4  byte lanes.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data, valid with ack, else 0.
- ch_data_o  out  N_CH*DATA_W  channel k at [k*DATA_W +: DATA_W], FIFO head.
- ch_valid_o  out  N_CH  head valid per channel.
- ch_ready_i  in  N_CH  array accepts channel k.
- res_data_i  in  32  result word.
- res_valid_i  in  1  result offered.
- res_ready_o  out  1  result FIFO not full.
- irq_o  out  1  result-available interrupt, registered.

## Operation
- Register map (offset = adr[7:0]):
  - 0x00 CTRL RW: bit0 enable, bit1 flush (self-clearing, reads 0), bit2 irq_en.
  - 0x04 STATUS RO: [7:0] ch_full, [15:8] ch_empty (unused channels read full=0, empty=1), bit16 res_nonempty, bit17 overflow sticky, bit18 underflow sticky. Write 1 to bit17/bit18 clears it.
  - 0x08 RES RO: read pops the result FIFO head.
  - 0x10+4k CH_k WO: push dat_i[DATA_W-1:0] into channel k, k<N_CH.
- Request accepted when stb&cyc&!ack. Acks are never back-to-back.
- Addresses outside the window or unmapped: acked, read 0, no side effect.
- A write with sel==0 is acked with no effect. Otherwise sel is ignored.
- Push to a full channel: dropped, overflow set. The full check uses the state before the same-cycle pop.
- RES read when empty: returns 0, no pop, underflow set.
- ch_valid_o[k] = enable & !empty_k. A transfer occurs when valid&ready. FIFOs are first-word-fall-through.
- Result capture: res_valid_i&res_ready_o pushes. res_ready_o = !res_full, regardless of enable.
- Flush empties all N_CH+1 FIFOs. It does not clear the sticky bits.
- irq_o = irq_en & res_nonempty, registered.
- Reset: ack 0, dat_o 0, CTRL 0, stickies 0, all FIFOs empty, ch_valid_o 0, irq_o 0, res_ready_o 0 while reset is held. Reset mid-transaction drops the request and no ack is issued.

## Timing
- Request sampled at edge T; ack and read data high for cycle T+1 only.
- A push is visible as count/ch_valid_o from T+1. A pop by RES read takes effect at T+1, and the popped word is the one on dat_o.
- CTRL write at T: enable/irq_en take effect from T+1. Flush empties the FIFOs at T+1, so ch_valid_o is 0 from T+1.
- Stream transfer at edge E: next head on ch_data_o after E, zero bubble.
- irq_o lags res_nonempty by one cycle.
- Flush at the same edge as a stream push/pop: flush wins and all FIFOs end empty.
- Pointer wrap is modulo DEPTH with an extra wrap bit for full/empty.

## Structure
- Package wb_sa_pkg holds:
  - register offsets (CTRL, STATUS, RES, CH_BASE);
  - CTRL bit indices (enable, flush, irq_en);
  - STATUS bit positions (ch_full, ch_empty, res_nonempty, overflow, underflow).
- Sub-module sync_fifo (WIDTH, DEPTH; push, pop, flush, full, empty, head) is instantiated N_CH times at DATA_W and once at 32.

## Test plan
- Reset then read 0x04 -> 0x0000_FF00 with N_CH=4 (empties incl. unused), ack exactly one cycle. ch_valid_o=0 and irq_o=0 throughout.
- Enable; write 0xA5 to 0x10, ch_ready_i[0]=0 -> ch_valid_o[0]=1, ch_data_o[7:0]=0xA5 from T+1. Raise ready -> one transfer, then valid=0.
- Write 5 words to CH_1 with DEPTH=4, ready low -> STATUS full bit1=1, overflow=1. Drain yields the first 4 words in order. Writing 0x0002_0000 to STATUS clears overflow.
- Offer results 0x1111_1111 and 0x2222_2222 with irq_en=1 -> irq_o=1. RES reads return them in order. A third read returns 0 and sets underflow, and irq_o falls.
- Fill CH_2, set flush -> empty from T+1, CTRL reads with bit1=0.
- Access adr 0x3000_0100 and 0x3000_0040 -> acked, read 0, no state change. Assert wb_rst_ni low mid-request -> no ack.

Source files
------------

// File: rtl/wb_sa_pkg.sv
// Shared definitions for the Wishbone-to-systolic-array bridge.
// Holds the register offsets, CTRL/STATUS bit positions and a decoded-request
// struct used by the top level.
package wb_sa_pkg;

    // Register offsets within the 256-byte window.
    localparam logic [7:0] OFF_CTRL    = 8'h00;
    localparam logic [7:0] OFF_STATUS  = 8'h04;
    localparam logic [7:0] OFF_RES     = 8'h08;
    localparam logic [7:0] OFF_CH_BASE = 8'h10;

    // CTRL bits.
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bits.
    localparam int ST_FULL_LSB     = 0;
    localparam int ST_EMPTY_LSB    = 8;
    localparam int ST_RES_NONEMPTY = 16;
    localparam int ST_OVERFLOW     = 17;
    localparam int ST_UNDERFLOW    = 18;

    // Decoded, accepted bus request (valid only in the cycle it is sampled).
    typedef struct packed {
        logic        rd;   // read inside the window
        logic        wr;   // write inside the window with a non-zero sel
        logic [7:0]  off;  // byte offset within the window
        logic [31:0] dat;  // write data
    } wb_req_t;

    // Offset of the push register for channel k.
    function automatic logic [7:0] ch_offset(input int k);
        return OFF_CH_BASE + 8'(4 * k);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   push, din     write an entry (ignored when full)
//   pop           retire the head (ignored when empty)
//   flush         empty the FIFO; wins over a same-cycle push/pop
//   full, empty   occupancy flags
//   head          current head entry (meaningful only when !empty)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra wrap bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Full is judged before any same-cycle pop, so a push into a full FIFO drops.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/wb_systolic_bridge.sv
// Wishbone slave feeding N_CH operand streams into a systolic array and
// collecting 32-bit results into a readback FIFO with an interrupt.
// Ports:
//   wb_clk_i, wb_rst_ni         clock, synchronous active-low reset
//   wbs_*                       Wishbone classic slave (single-cycle ack)
//   ch_data_o/valid_o/ready_i   per-channel operand streams (FIFO heads)
//   res_data_i/valid_i/ready_o  result capture stream
//   irq_o                       registered result-available interrupt
module wb_systolic_bridge
    import wb_sa_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          N_CH      = 4,
    parameter int          DATA_W    = 8,
    parameter int          DEPTH     = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [N_CH*DATA_W-1:0]   ch_data_o,
    output logic [N_CH-1:0]          ch_valid_o,
    input  logic [N_CH-1:0]          ch_ready_i,
    input  logic [31:0]              res_data_i,
    input  logic                     res_valid_i,
    output logic                     res_ready_o,
    output logic                     irq_o
);
    logic        ack, enable, irq_en, overflow, underflow, irq;
    logic [31:0] dat;

    // ------------------------------------------------------------------
    // Request decode. The !ack term guarantees at least one idle cycle
    // between acknowledges even if the master holds stb.
    // ------------------------------------------------------------------
    logic    accept, in_win;
    wb_req_t req;

    assign accept  = wbs_stb_i && wbs_cyc_i && !ack;
    assign in_win  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req.rd  = accept && in_win && !wbs_we_i;
    assign req.wr  = accept && in_win && wbs_we_i && (wbs_sel_i != 4'b0);
    assign req.off = wbs_adr_i[7:0];
    assign req.dat = wbs_dat_i;

    logic ctrl_wr, status_wr, res_rd, flush;
    assign ctrl_wr   = req.wr && (req.off == OFF_CTRL);
    assign status_wr = req.wr && (req.off == OFF_STATUS);
    assign res_rd    = req.rd && (req.off == OFF_RES);
    // Flush acts at the same edge that samples the CTRL write, so the FIFOs
    // are already empty in the ack cycle; the bit itself is never stored.
    assign flush     = ctrl_wr && req.dat[CTRL_FLUSH];

    // ------------------------------------------------------------------
    // Operand channels
    // ------------------------------------------------------------------
    logic [N_CH-1:0]             ch_wr, ch_push, ch_pop, ch_full, ch_empty;
    logic [N_CH-1:0][DATA_W-1:0] ch_head;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign ch_wr[k]      = req.wr && (req.off == ch_offset(k));
        assign ch_push[k]    = ch_wr[k] && !ch_full[k];
        assign ch_valid_o[k] = enable && !ch_empty[k];
        assign ch_pop[k]     = ch_valid_o[k] && ch_ready_i[k];

        sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_ch_fifo (
            .clk   (wb_clk_i),
            .rst_n (wb_rst_ni),
            .push  (ch_push[k]),
            .pop   (ch_pop[k]),
            .flush (flush),
            .din   (req.dat[DATA_W-1:0]),
            .full  (ch_full[k]),
            .empty (ch_empty[k]),
            .head  (ch_head[k])
        );
    end

    assign ch_data_o = ch_head;

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    logic        res_full, res_empty, res_push, res_pop;
    logic [31:0] res_head;

    // Held low during reset so no result is taken while the bridge is down.
    assign res_ready_o = wb_rst_ni && !res_full;
    assign res_push    = res_valid_i && res_ready_o;
    assign res_pop     = res_rd && !res_empty;

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_res_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .push  (res_push),
        .pop   (res_pop),
        .flush (flush),
        .din   (res_data_i),
        .full  (res_full),
        .empty (res_empty),
        .head  (res_head)
    );

    // ------------------------------------------------------------------
    // Status / read mux
    // ------------------------------------------------------------------
    logic [7:0]  st_full, st_empty;
    logic [31:0] status_word, rdata;

    // Channels beyond N_CH report as permanently empty, never full.
    always_comb begin
        st_full  = '0;
        st_empty = '1;
        for (int k = 0; k < N_CH; k++) begin
            st_full[k]  = ch_full[k];
            st_empty[k] = ch_empty[k];
        end
    end

    always_comb begin
        status_word                              = '0;
        status_word[ST_FULL_LSB  +: 8]           = st_full;
        status_word[ST_EMPTY_LSB +: 8]           = st_empty;
        status_word[ST_RES_NONEMPTY]             = !res_empty;
        status_word[ST_OVERFLOW]                 = overflow;
        status_word[ST_UNDERFLOW]                = underflow;
    end

    always_comb begin
        rdata = '0;
        if (req.rd) begin
            case (req.off)
                OFF_CTRL: begin
                    rdata[CTRL_ENABLE] = enable;
                    rdata[CTRL_IRQ_EN] = irq_en;
                end
                OFF_STATUS: rdata = status_word;
                OFF_RES:    rdata = res_empty ? 32'h0 : res_head;
                default:    rdata = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ack       <= 1'b0;
            dat       <= '0;
            enable    <= 1'b0;
            irq_en    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            irq       <= 1'b0;
        end else begin
            ack <= accept;
            dat <= rdata;
            irq <= irq_en && !res_empty;

            if (ctrl_wr) begin
                enable <= req.dat[CTRL_ENABLE];
                irq_en <= req.dat[CTRL_IRQ_EN];
            end

            // Set and clear come from different requests, so they never collide.
            if (|(ch_wr & ch_full))
                overflow <= 1'b1;
            else if (status_wr && req.dat[ST_OVERFLOW])
                overflow <= 1'b0;

            if (res_rd && res_empty)
                underflow <= 1'b1;
            else if (status_wr && req.dat[ST_UNDERFLOW])
                underflow <= 1'b0;
        end
    end

    assign wbs_ack_o = ack;
    assign wbs_dat_o = dat;
    assign irq_o     = irq;

endmodule

// File: tb/tb_wb_systolic_bridge.sv
module tb_wb_systolic_bridge;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [31:0] ch_data;
    logic [3:0]  ch_valid;
    logic [3:0]  ch_ready = 4'h0;
    logic [31:0] res_data = '0;
    logic        res_valid = 1'b0;
    logic        res_ready, irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_systolic_bridge #(.BASE_ADDR(BASE), .N_CH(4), .DATA_W(8), .DEPTH(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .ch_data_o  (ch_data),
        .ch_valid_o (ch_valid),
        .ch_ready_i (ch_ready),
        .res_data_i (res_data),
        .res_valid_i(res_valid),
        .res_ready_o(res_ready),
        .irq_o      (irq)
    );

    // One bus transaction. Reports whether an ack arrived (bounded wait),
    // the read data, ch_valid in the ack cycle, and whether ack was still
    // high one cycle later.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic acked, output logic [31:0] rd,
                        output logic [3:0] vld, output logic ack_long);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
        acked = 1'b0; rd = '0; vld = '0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1; rd = rdat; vld = ch_valid;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        ack_long = ack;
    endtask

    task automatic test_reset();
        logic a, l; logic [31:0] d; logic [3:0] v;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ch_valid !== 4'h0) begin errors++; $display("FAIL reset_valid got %h want 0", ch_valid); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL reset_res_ready got %b want 0", res_ready); end
        checks++; if (ack !== 1'b0 || rdat !== 32'h0) begin errors++; $display("FAIL reset_bus got ack=%b dat=%h want 0/0", ack, rdat); end
        @(negedge clk); rst_n = 1'b1;
        xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, a, d, v, l);
        checks++; if (a !== 1'b1 || l !== 1'b0) begin errors++; $display("FAIL reset_status_ack got ack=%b long=%b want 1/0", a, l); end
        checks++; if (d !== 32'h0000_FF00) begin errors++; $display("FAIL reset_status got %h want 0000ff00", d); end
        checks++; if (res_ready !== 1'b1 || irq !== 1'b0 || ch_valid !== 4'h0) begin
            errors++; $display("FAIL post_reset_outs got rr=%b irq=%b vld=%h want 1/0/0", res_ready, irq, ch_valid); end
    endtask

    task automatic test_stream();
        logic a, l; logic [31:0] d; logic [3:0] v;
        xfer(1'b1, BASE + 32'h00, 32'h1, 4'hF, a, d, v, l);
        xfer(1'b1, BASE + 32'h10, 32'hA5, 4'hF, a, d, v, l);
        checks++; if (v[0] !== 1'b1) begin errors++; $display("FAIL stream_valid_t1 got %b want 1", v[0]); end
        checks++; if (ch_data[7:0] !== 8'hA5) begin errors++; $display("FAIL stream_data got %h want a5", ch_data[7:0]); end
        @(negedge clk); ch_ready[0] = 1'b1;
        @(posedge clk); #1;
        checks++; if (ch_valid[0] !== 1'b0) begin errors++; $display("FAIL stream_drain got %b want 0", ch_valid[0]); end
        @(negedge clk); ch_ready[0] = 1'b0;
    endtask

    task automatic test_overflow();
        logic a, l; logic [31:0] d; logic [3:0] v;
        logic [7:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) xfer(1'b1, BASE + 32'h14, {24'h0, words[i]}, 4'h1, a, d, v, l);
        xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, a, d, v, l);
        checks++; if (d !== 32'h0002_FD02) begin errors++; $display("FAIL ovf_status got %h want 0002fd02", d); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ch_valid[1] !== 1'b1 || ch_data[15:8] !== words[i]) begin
                errors++; $display("FAIL ovf_drain%0d got v=%b d=%h want 1/%h", i, ch_valid[1], ch_data[15:8], words[i]);
            end
            ch_ready[1] = 1'b1;
            @(negedge clk);
        end
        checks++; if (ch_valid[1] !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b want 0", ch_valid[1]); end
        ch_ready[1] = 1'b0;
        xfer(1'b1, BASE + 32'h04, 32'h0002_0000, 4'hF, a, d, v, l);
        xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, a, d, v, l);
        checks++; if (d !== 32'h0000_FF00) begin errors++; $display("FAIL ovf_clear got %h want 0000ff00", d); end
    endtask

    task automatic test_results();
        logic a, l; logic [31:0] d; logic [3:0] v;
        xfer(1'b1, BASE + 32'h00, 32'h5, 4'hF, a, d, v, l);
        @(negedge clk);
        res_valid = 1'b1; res_data = 32'h1111_1111;
        @(negedge clk); res_data = 32'h2222_2222;
        @(negedge clk); res_valid = 1'b0; res_data = '0;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL res_irq got %b want 1", irq); end
        xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF, a, d, v, l);
        checks++; if (d !== 32'h1111_1111) begin errors++; $display("FAIL res_rd0 got %h want 11111111", d); end
        xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF, a, d, v, l);
        checks++; if (d !== 32'h2222_2222) begin errors++; $display("FAIL res_rd1 got %h want 22222222", d); end
        xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF, a, d, v, l);
        checks++; if (a !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL res_empty_rd got ack=%b d=%h want 1/0", a, d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL res_irq_fall got %b want 0", irq); end
        xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, a, d, v, l);
        checks++; if (d !== 32'h0004_FF00) begin errors++; $display("FAIL res_underflow got %h want 0004ff00", d); end
        xfer(1'b1, BASE + 32'h04, 32'h0004_0000, 4'hF, a, d, v, l);
        xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, a, d, v, l);
        checks++; if (d !== 32'h0000_FF00) begin errors++; $display("FAIL res_uf_clear got %h want 0000ff00", d); end
    endtask

    task automatic test_flush();
        logic a, l; logic [31:0] d; logic [3:0] v;
        xfer(1'b1, BASE + 32'h00, 32'h1, 4'hF, a, d, v, l);
        for (int i = 0; i < 4; i++) xfer(1'b1, BASE + 32'h18, 32'h60 + i, 4'hF, a, d, v, l);
        checks++; if (ch_valid[2] !== 1'b1) begin errors++; $display("FAIL flush_filled got %b want 1", ch_valid[2]); end
        xfer(1'b1, BASE + 32'h00, 32'h3, 4'hF, a, d, v, l);
        checks++; if (v !== 4'h0) begin errors++; $display("FAIL flush_t1 got %h want 0", v); end
        xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, a, d, v, l);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL flush_ctrl got %h want 1", d); end
        xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, a, d, v, l);
        checks++; if (d !== 32'h0000_FF00) begin errors++; $display("FAIL flush_status got %h want 0000ff00", d); end
    endtask

    task automatic test_unmapped();
        logic a, l; logic [31:0] d; logic [3:0] v;
        xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, a, d, v, l);
        checks++; if (a !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unm_rd_out got ack=%b d=%h want 1/0", a, d); end
        xfer(1'b0, BASE + 32'h40, 32'h0, 4'hF, a, d, v, l);
        checks++; if (a !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unm_rd_hole got ack=%b d=%h want 1/0", a, d); end
        xfer(1'b1, BASE + 32'h100, 32'h0000_0006, 4'hF, a, d, v, l);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL unm_wr_ack got %b want 1", a); end
        xfer(1'b1, BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, a, d, v, l);
        xfer(1'b1, BASE + 32'h00, 32'h0, 4'h0, a, d, v, l);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL sel0_ack got %b want 1", a); end
        xfer(1'b1, BASE + 32'h10, 32'h77, 4'h0, a, d, v, l);
        xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, a, d, v, l);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL unm_ctrl got %h want 1", d); end
        xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, a, d, v, l);
        checks++; if (d !== 32'h0000_FF00) begin errors++; $display("FAIL unm_status got %h want 0000ff00", d); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] seen;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h04; sel = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            seen[i] = ack;
        end
        stb = 1'b0; cyc = 1'b0;
        checks++; if (seen !== 3'b101) begin errors++; $display("FAIL b2b_ack got %b want 101", seen); end
        @(posedge clk);
    endtask

    task automatic test_reset_mid();
        logic a, l; logic [31:0] d; logic [3:0] v;
        logic [1:0] seen;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h04; sel = 4'hF;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            seen[i] = ack;
        end
        checks++; if (seen !== 2'b00) begin errors++; $display("FAIL rst_mid_ack got %b want 00", seen); end
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; rst_n = 1'b1;
        xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, a, d, v, l);
        checks++; if (a !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL rst_mid_ctrl got ack=%b d=%h want 1/0", a, d); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_results();
        test_flush();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
